regfile_read_stage: RTL and testbench

- Parametrised register-read stage between issue and execute; successor of the fixed dual-lane read block.
- Holds the architectural register file with NUM_WB write ports and NUM_LANES read lanes, two operands per lane.
- Adds enable-gated writeback bypass, r0 hardwired to zero, a busy-bit scoreboard that stalls RAW/WAW hazards, valid/ready handshaking and flush.

---
 rtl/regfile_read_stage_pkg.sv | 30 +++
 rtl/rf_scoreboard.sv | 79 +++++++
 rtl/regfile_read_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_regfile_read_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_read_stage_pkg.sv
// Shared encodings and micro-op field layout for the register-read stage.
package regfile_read_stage_pkg;

    // Micro-op layout: [1:0] src1 select, [3:2] src2 select, [4] rd write enable,
    // [7:5] opaque to this stage and passed through.
    localparam int unsigned WIDTH_UOP    = 8;
    localparam int unsigned UOP_SEL_W    = 2;
    localparam int unsigned UOP_SRC1_LSB = 0;
    localparam int unsigned UOP_SRC1_MSB = UOP_SRC1_LSB + UOP_SEL_W - 1;
    localparam int unsigned UOP_SRC2_LSB = 2;
    localparam int unsigned UOP_SRC2_MSB = UOP_SRC2_LSB + UOP_SEL_W - 1;
    localparam int unsigned UOP_RD_WE    = 4;

    localparam int unsigned EXP_W = 6;

    typedef enum logic [1:0] {
        CTRL_SRC1_RF    = 2'd0,
        CTRL_SRC1_PC    = 2'd1,
        CTRL_SRC1_ZERO  = 2'd2,
        CTRL_SRC1_CNTID = 2'd3
    } src1_sel_e;

    typedef enum logic [1:0] {
        CTRL_SRC2_RF   = 2'd0,
        CTRL_SRC2_IMM  = 2'd1,
        CTRL_SRC2_CNTL = 2'd2,
        CTRL_SRC2_CNTH = 2'd3
    } src2_sel_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set when a writing
// instruction is accepted and cleared by writeback. Reports per-lane hazards.
module rf_scoreboard
    import regfile_read_stage_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned NUM_WB    = 2,
    parameter int unsigned NREG      = 32,
    localparam int unsigned AW       = $clog2(NREG)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_set,
    input  logic [NUM_LANES-1:0]    i_lane_en,
    input  logic [NUM_LANES-1:0]    i_rd_we,
    input  logic [NUM_LANES-1:0]    i_rj_used,
    input  logic [NUM_LANES-1:0]    i_rk_used,
    input  logic [NUM_LANES*AW-1:0] i_rd,
    input  logic [NUM_LANES*AW-1:0] i_rj,
    input  logic [NUM_LANES*AW-1:0] i_rk,
    input  logic [NUM_WB-1:0]       i_wb_clr,
    input  logic [NUM_WB*AW-1:0]    i_wb_addr,
    output logic [NUM_LANES-1:0]    o_lane_hazard
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_busy_eff;
    logic [NREG-1:0] w_busy_d;

    // Registers released by writeback this cycle.
    always_comb begin
        w_clr_mask = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (i_wb_clr[i]) begin
                w_clr_mask[i_wb_addr[i*AW +: AW]] = 1'b1;
            end
        end
    end

    // Registers claimed by the group being accepted this cycle.
    always_comb begin
        w_set_mask = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (i_set && i_lane_en[l] && i_rd_we[l]) begin
                w_set_mask[i_rd[l*AW +: AW]] = 1'b1;
            end
        end
    end

    // A same-cycle clear already unblocks a reader; a same-cycle set wins over clear.
    always_comb begin
        w_busy_eff    = r_busy & ~w_clr_mask;
        w_busy_d      = w_busy_eff | w_set_mask;
        w_busy_d[0]   = 1'b0;
    end

    // Per-lane RAW/WAW hazard query against the effective busy bits.
    always_comb begin
        o_lane_hazard = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            o_lane_hazard[l] = i_lane_en[l] &&
                ((i_rj_used[l] && w_busy_eff[i_rj[l*AW +: AW]]) ||
                 (i_rk_used[l] && w_busy_eff[i_rk[l*AW +: AW]]) ||
                 (i_rd_we[l]   && w_busy_eff[i_rd[l*AW +: AW]]));
        end
    end

    // Busy-bit state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

endmodule

// File: rtl/regfile_read_stage.sv
// Register-read stage: register file with writeback bypass, operand select,
// scoreboard-based stalling and a single valid/ready output register.
module regfile_read_stage
    import regfile_read_stage_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned NUM_WB     = 2,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned COUNTER_ID = 0,
    localparam int unsigned AW        = $clog2(NREG)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES-1:0]           in_lane_en,
    input  logic [NUM_LANES*WIDTH_UOP-1:0] in_uop,
    input  logic [NUM_LANES*AW-1:0]        in_rd,
    input  logic [NUM_LANES*AW-1:0]        in_rj,
    input  logic [NUM_LANES*AW-1:0]        in_rk,
    input  logic [NUM_LANES*32-1:0]        in_pc,
    input  logic [NUM_LANES*32-1:0]        in_pc_next,
    input  logic [NUM_LANES*32-1:0]        in_imm,
    input  logic [NUM_LANES*EXP_W-1:0]     in_exp,
    input  logic [63:0]                    stable_counter,
    input  logic [NUM_WB-1:0]              wb_en,
    input  logic [NUM_WB-1:0]              wb_clr,
    input  logic [NUM_WB*AW-1:0]           wb_addr,
    input  logic [NUM_WB*XLEN-1:0]         wb_data,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES-1:0]           out_lane_en,
    output logic [NUM_LANES*WIDTH_UOP-1:0] out_uop,
    output logic [NUM_LANES*AW-1:0]        out_rd,
    output logic [NUM_LANES*AW-1:0]        out_rj,
    output logic [NUM_LANES*AW-1:0]        out_rk,
    output logic [NUM_LANES*32-1:0]        out_pc,
    output logic [NUM_LANES*32-1:0]        out_pc_next,
    output logic [NUM_LANES*EXP_W-1:0]     out_exp,
    output logic [NUM_LANES*XLEN-1:0]      out_src1,
    output logic [NUM_LANES*XLEN-1:0]      out_src2
);

    logic [XLEN-1:0] r_rf [NREG];

    logic                           r_out_valid;
    logic [NUM_LANES-1:0]           r_lane_en;
    logic [NUM_LANES*WIDTH_UOP-1:0] r_uop;
    logic [NUM_LANES*AW-1:0]        r_rd;
    logic [NUM_LANES*AW-1:0]        r_rj;
    logic [NUM_LANES*AW-1:0]        r_rk;
    logic [NUM_LANES*32-1:0]        r_pc;
    logic [NUM_LANES*32-1:0]        r_pc_next;
    logic [NUM_LANES*EXP_W-1:0]     r_exp;
    logic [NUM_LANES*XLEN-1:0]      r_src1;
    logic [NUM_LANES*XLEN-1:0]      r_src2;

    src1_sel_e                 w_sel1   [NUM_LANES];
    src2_sel_e                 w_sel2   [NUM_LANES];
    logic [XLEN-1:0]           w_rj_val [NUM_LANES];
    logic [XLEN-1:0]           w_rk_val [NUM_LANES];
    logic [NUM_LANES-1:0]      w_rd_we;
    logic [NUM_LANES-1:0]      w_rj_used;
    logic [NUM_LANES-1:0]      w_rk_used;
    logic [NUM_LANES-1:0]      w_lane_hazard;
    logic [NUM_LANES*XLEN-1:0] w_src1;
    logic [NUM_LANES*XLEN-1:0] w_src2;
    logic                      w_accept;

    // Decode the micro-op fields this stage cares about.
    always_comb begin
        w_rd_we   = '0;
        w_rj_used = '0;
        w_rk_used = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_sel1[l]    = src1_sel_e'(in_uop[l*WIDTH_UOP + UOP_SRC1_LSB +: UOP_SEL_W]);
            w_sel2[l]    = src2_sel_e'(in_uop[l*WIDTH_UOP + UOP_SRC2_LSB +: UOP_SEL_W]);
            w_rd_we[l]   = in_uop[l*WIDTH_UOP + UOP_RD_WE] && (in_rd[l*AW +: AW] != '0);
            w_rj_used[l] = (w_sel1[l] == CTRL_SRC1_RF);
            w_rk_used[l] = (w_sel2[l] == CTRL_SRC2_RF);
        end
    end

    // Register reads with writeback bypass; later ports override earlier ones.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_rj_val[l] = r_rf[in_rj[l*AW +: AW]];
            w_rk_val[l] = r_rf[in_rk[l*AW +: AW]];
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_en[i] && (wb_addr[i*AW +: AW] == in_rj[l*AW +: AW])) begin
                    w_rj_val[l] = wb_data[i*XLEN +: XLEN];
                end
                if (wb_en[i] && (wb_addr[i*AW +: AW] == in_rk[l*AW +: AW])) begin
                    w_rk_val[l] = wb_data[i*XLEN +: XLEN];
                end
            end
            if (in_rj[l*AW +: AW] == '0) begin
                w_rj_val[l] = '0;
            end
            if (in_rk[l*AW +: AW] == '0) begin
                w_rk_val[l] = '0;
            end
        end
    end

    // Operand source multiplexers.
    always_comb begin
        w_src1 = '0;
        w_src2 = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            unique case (w_sel1[l])
                CTRL_SRC1_RF:    w_src1[l*XLEN +: XLEN] = w_rj_val[l];
                CTRL_SRC1_PC:    w_src1[l*XLEN +: XLEN] = XLEN'(in_pc[l*32 +: 32]);
                CTRL_SRC1_ZERO:  w_src1[l*XLEN +: XLEN] = '0;
                CTRL_SRC1_CNTID: w_src1[l*XLEN +: XLEN] = XLEN'(COUNTER_ID);
                default:         w_src1[l*XLEN +: XLEN] = '0;
            endcase
            unique case (w_sel2[l])
                CTRL_SRC2_RF:    w_src2[l*XLEN +: XLEN] = w_rk_val[l];
                CTRL_SRC2_IMM:   w_src2[l*XLEN +: XLEN] = XLEN'(in_imm[l*32 +: 32]);
                CTRL_SRC2_CNTL:  w_src2[l*XLEN +: XLEN] = XLEN'(stable_counter[31:0]);
                CTRL_SRC2_CNTH:  w_src2[l*XLEN +: XLEN] = XLEN'(stable_counter[63:32]);
                default:         w_src2[l*XLEN +: XLEN] = '0;
            endcase
        end
    end

    rf_scoreboard #(
        .NUM_LANES (NUM_LANES),
        .NUM_WB    (NUM_WB),
        .NREG      (NREG)
    ) u_rf_scoreboard (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_set         (w_accept),
        .i_lane_en     (in_lane_en),
        .i_rd_we       (w_rd_we),
        .i_rj_used     (w_rj_used),
        .i_rk_used     (w_rk_used),
        .i_rd          (in_rd),
        .i_rj          (in_rj),
        .i_rk          (in_rk),
        .i_wb_clr      (wb_clr),
        .i_wb_addr     (wb_addr),
        .o_lane_hazard (w_lane_hazard)
    );

    // Handshake: the whole group stalls if any enabled lane has a hazard.
    always_comb begin
        in_ready = !(|w_lane_hazard) && (!r_out_valid || out_ready) && !flush;
        w_accept = in_valid && in_ready;
    end

    // Register file; r0 is never written and stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_rf[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_en[i] && (wb_addr[i*AW +: AW] != '0)) begin
                    r_rf[wb_addr[i*AW +: AW]] <= wb_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Output valid: flush kills, accept loads, consumption drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Output payload: captured on accept, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane_en <= '0;
            r_uop     <= '0;
            r_rd      <= '0;
            r_rj      <= '0;
            r_rk      <= '0;
            r_pc      <= '0;
            r_pc_next <= '0;
            r_exp     <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
        end else if (w_accept) begin
            r_lane_en <= in_lane_en;
            r_uop     <= in_uop;
            r_rd      <= in_rd;
            r_rj      <= in_rj;
            r_rk      <= in_rk;
            r_pc      <= in_pc;
            r_pc_next <= in_pc_next;
            r_exp     <= in_exp;
            r_src1    <= w_src1;
            r_src2    <= w_src2;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_lane_en = r_lane_en;
    assign out_uop     = r_uop;
    assign out_rd      = r_rd;
    assign out_rj      = r_rj;
    assign out_rk      = r_rk;
    assign out_pc      = r_pc;
    assign out_pc_next = r_pc_next;
    assign out_exp     = r_exp;
    assign out_src1    = r_src1;
    assign out_src2    = r_src2;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Scoreboard bench for regfile_read_stage: directed scenarios plus random traffic
// checked against a behavioural model of the register file and busy bits.
module tb_regfile_read_stage;
    import regfile_read_stage_pkg::*;

    localparam int L   = 2;
    localparam int W   = 2;
    localparam int AW  = 5;
    localparam int NR  = 32;
    localparam int U   = WIDTH_UOP;
    localparam logic [31:0] CID = 32'h5A;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [L-1:0]     in_lane_en;
    logic [L*U-1:0]   in_uop;
    logic [L*AW-1:0]  in_rd, in_rj, in_rk;
    logic [L*32-1:0]  in_pc, in_pc_next, in_imm;
    logic [L*6-1:0]   in_exp;
    logic [63:0]      stable_counter;
    logic [W-1:0]     wb_en, wb_clr;
    logic [W*AW-1:0]  wb_addr;
    logic [W*32-1:0]  wb_data;
    logic             flush, out_valid, out_ready;
    logic [L-1:0]     out_lane_en;
    logic [L*U-1:0]   out_uop;
    logic [L*AW-1:0]  out_rd, out_rj, out_rk;
    logic [L*32-1:0]  out_pc, out_pc_next;
    logic [L*6-1:0]   out_exp;
    logic [L*32-1:0]  out_src1, out_src2;

    regfile_read_stage #(
        .NUM_LANES (L), .NUM_WB (W), .XLEN (32), .NREG (NR), .COUNTER_ID (CID)
    ) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
        .in_lane_en (in_lane_en), .in_uop (in_uop), .in_rd (in_rd), .in_rj (in_rj),
        .in_rk (in_rk), .in_pc (in_pc), .in_pc_next (in_pc_next), .in_imm (in_imm),
        .in_exp (in_exp), .stable_counter (stable_counter), .wb_en (wb_en),
        .wb_clr (wb_clr), .wb_addr (wb_addr), .wb_data (wb_data), .flush (flush),
        .out_valid (out_valid), .out_ready (out_ready), .out_lane_en (out_lane_en),
        .out_uop (out_uop), .out_rd (out_rd), .out_rj (out_rj), .out_rk (out_rk),
        .out_pc (out_pc), .out_pc_next (out_pc_next), .out_exp (out_exp),
        .out_src1 (out_src1), .out_src2 (out_src2)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]  src1;
        logic [63:0]  src2;
        logic [187:0] ctl;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_rf [NR];
    bit          m_busy [NR];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (wb_en[i] && wb_addr[i*AW +: AW] == r) return wb_data[i*32 +: 32];
        end
        return m_rf[r];
    endfunction

    function automatic bit m_cleared(input logic [4:0] r);
        for (int i = 0; i < W; i++) begin
            if (wb_clr[i] && wb_addr[i*AW +: AW] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_blocked(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r] && !m_cleared(r);
    endfunction

    function automatic bit model_ready();
        bit          haz = 1'b0;
        logic [U-1:0] u;
        for (int l = 0; l < L; l++) begin
            u = in_uop[l*U +: U];
            if (in_lane_en[l]) begin
                if (u[UOP_SRC1_MSB:UOP_SRC1_LSB] == CTRL_SRC1_RF && m_blocked(in_rj[l*AW +: AW]))
                    haz = 1'b1;
                if (u[UOP_SRC2_MSB:UOP_SRC2_LSB] == CTRL_SRC2_RF && m_blocked(in_rk[l*AW +: AW]))
                    haz = 1'b1;
                if (u[UOP_RD_WE] && m_blocked(in_rd[l*AW +: AW]))
                    haz = 1'b1;
            end
        end
        return !haz && (q.size() == 0 || out_ready) && !flush;
    endfunction

    function automatic exp_t model_out();
        exp_t         e;
        logic [U-1:0] u;
        e.ctl = {in_lane_en, in_uop, in_rd, in_rj, in_rk, in_pc, in_pc_next, in_exp};
        e.src1 = '0;
        e.src2 = '0;
        for (int l = 0; l < L; l++) begin
            u = in_uop[l*U +: U];
            case (u[UOP_SRC1_MSB:UOP_SRC1_LSB])
                CTRL_SRC1_RF:   e.src1[l*32 +: 32] = m_read(in_rj[l*AW +: AW]);
                CTRL_SRC1_PC:   e.src1[l*32 +: 32] = in_pc[l*32 +: 32];
                CTRL_SRC1_ZERO: e.src1[l*32 +: 32] = 32'd0;
                default:        e.src1[l*32 +: 32] = CID;
            endcase
            case (u[UOP_SRC2_MSB:UOP_SRC2_LSB])
                CTRL_SRC2_RF:   e.src2[l*32 +: 32] = m_read(in_rk[l*AW +: AW]);
                CTRL_SRC2_IMM:  e.src2[l*32 +: 32] = in_imm[l*32 +: 32];
                CTRL_SRC2_CNTL: e.src2[l*32 +: 32] = stable_counter[31:0];
                default:        e.src2[l*32 +: 32] = stable_counter[63:32];
            endcase
        end
        return e;
    endfunction

    task automatic model_commit(input bit acc);
        logic [U-1:0] u;
        for (int r = 0; r < NR; r++) if (m_cleared(5'(r))) m_busy[r] = 1'b0;
        if (acc) begin
            for (int l = 0; l < L; l++) begin
                u = in_uop[l*U +: U];
                if (in_lane_en[l] && u[UOP_RD_WE] && in_rd[l*AW +: AW] != 5'd0)
                    m_busy[in_rd[l*AW +: AW]] = 1'b1;
            end
        end
        for (int i = 0; i < W; i++) begin
            if (wb_en[i] && wb_addr[i*AW +: AW] != 5'd0)
                m_rf[wb_addr[i*AW +: AW]] = wb_data[i*32 +: 32];
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_rf[r]   = 32'd0;
            m_busy[r] = 1'b0;
        end
        q.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        in_valid = 0; in_lane_en = '0; in_uop = '0; in_rd = '0; in_rj = '0; in_rk = '0;
        in_pc = '0; in_pc_next = '0; in_imm = '0; in_exp = '0; stable_counter = '0;
        wb_en = '0; wb_clr = '0; wb_addr = '0; wb_data = '0; flush = 0; out_ready = 1;
    endtask

    task automatic set_lane(input int l, input bit en, input logic [1:0] s1,
                            input logic [1:0] s2, input bit we, input logic [4:0] rd,
                            input logic [4:0] rj, input logic [4:0] rk, input logic [31:0] imm);
        logic [U-1:0] u;
        u = U'($urandom_range(0, 255));
        u[UOP_SRC1_MSB:UOP_SRC1_LSB] = s1;
        u[UOP_SRC2_MSB:UOP_SRC2_LSB] = s2;
        u[UOP_RD_WE] = we;
        in_lane_en[l] = en;
        in_uop[l*U +: U] = u;
        in_rd[l*AW +: AW] = rd;
        in_rj[l*AW +: AW] = rj;
        in_rk[l*AW +: AW] = rk;
        in_imm[l*32 +: 32] = imm;
        in_pc[l*32 +: 32] = $urandom;
        in_pc_next[l*32 +: 32] = $urandom;
        in_exp[l*6 +: 6] = 6'($urandom_range(0, 63));
    endtask

    task automatic rand_inputs();
        in_valid = ($urandom_range(0, 9) < 8);
        for (int l = 0; l < L; l++) begin
            set_lane(l, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < W; i++) begin
            wb_en[i]  = ($urandom_range(0, 2) == 0);
            wb_clr[i] = ($urandom_range(0, 2) == 0);
            wb_addr[i*AW +: AW] = 5'($urandom_range(0, 7));
            wb_data[i*32 +: 32] = $urandom;
        end
        stable_counter = {$urandom, $urandom};
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 19) == 0);
    endtask

    // One clock: check handshake before the edge, push expectation, update model.
    task automatic cycle();
        bit rdy, acc;
        @(negedge clk);
        chk("out_valid", out_valid, (q.size() != 0));
        rdy = model_ready();
        chk("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        if (flush && q.size() != 0 && !out_ready) void'(q.pop_front());
        if (acc) q.push_back(model_out());
        @(posedge clk);
        model_commit(acc);
        #1;
    endtask

    // Monitor: compare each group as it is handed to execute.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && out_valid && out_ready) begin
            chk("mon_q_nonempty", (q.size() != 0), 1'b1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("mon_src1", out_src1, e.src1);
                chk("mon_src2", out_src2, e.src2);
                chk("mon_ctl", {out_lane_en, out_uop, out_rd, out_rj, out_rk, out_pc,
                                out_pc_next, out_exp}, e.ctl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_src", {out_src1, out_src2}, 128'd0);
        chk("rst_ctl", {out_lane_en, out_uop, out_pc, out_exp}, 96'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Read after reset.
        set_lane(0, 1, CTRL_SRC1_RF, CTRL_SRC2_IMM, 0, 0, 5, 0, 32'h1234);
        in_valid = 1;
        cycle();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_src1", out_src1[31:0], 32'h0);
        chk("t1_src2", out_src2[31:0], 32'h1234);

        // Bypass priority and RF update.
        clear_inputs();
        wb_en = 2'b11; wb_addr = {5'd7, 5'd7}; wb_data = {32'hB, 32'hA};
        set_lane(0, 1, CTRL_SRC1_RF, CTRL_SRC2_IMM, 0, 0, 7, 0, 0);
        in_valid = 1;
        cycle();
        chk("byp_src1", out_src1[31:0], 32'hB);
        clear_inputs();
        set_lane(0, 1, CTRL_SRC1_RF, CTRL_SRC2_RF, 0, 0, 7, 7, 0);
        in_valid = 1;
        cycle();
        chk("byp_rf7", {out_src2[31:0], out_src1[31:0]}, {32'hB, 32'hB});

        // r0 stays zero.
        clear_inputs();
        wb_en = 2'b01; wb_addr = '0; wb_data = {32'h0, 32'hFFFF};
        set_lane(0, 1, CTRL_SRC1_RF, CTRL_SRC2_RF, 0, 0, 0, 0, 0);
        in_valid = 1;
        cycle();
        chk("r0_same", {out_src2[31:0], out_src1[31:0]}, 64'd0);
        clear_inputs();
        set_lane(0, 1, CTRL_SRC1_RF, CTRL_SRC2_IMM, 0, 0, 0, 0, 0);
        in_valid = 1;
        cycle();
        chk("r0_later", out_src1[31:0], 32'd0);

        // RAW stall released by writeback in the same cycle.
        clear_inputs();
        set_lane(0, 1, CTRL_SRC1_ZERO, CTRL_SRC2_IMM, 1, 3, 0, 0, 0);
        in_valid = 1;
        cycle();
        clear_inputs();
        set_lane(0, 1, CTRL_SRC1_RF, CTRL_SRC2_IMM, 0, 0, 3, 0, 0);
        in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("raw_stall", in_ready, 1'b0);
            cycle();
        end
        wb_en = 2'b01; wb_clr = 2'b01; wb_addr = {5'd0, 5'd3}; wb_data = {32'd0, 32'h55};
        #1 chk("raw_release", in_ready, 1'b1);
        cycle();
        chk("raw_src1", out_src1[31:0], 32'h55);

        // Backpressure hold, then flush with busy bits preserved.
        clear_inputs();
        set_lane(0, 1, CTRL_SRC1_ZERO, CTRL_SRC2_IMM, 1, 9, 0, 0, 32'h77);
        in_valid = 1;
        cycle();
        out_ready = 0;
        set_lane(0, 1, CTRL_SRC1_ZERO, CTRL_SRC2_IMM, 0, 0, 0, 0, 32'h88);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ready", in_ready, 1'b0);
            chk("hold_src2", out_src2[31:0], 32'h77);
            chk("hold_valid", out_valid, 1'b1);
            cycle();
        end
        flush = 1;
        cycle();
        chk("flush_valid", out_valid, 1'b0);
        clear_inputs();
        set_lane(0, 1, CTRL_SRC1_RF, CTRL_SRC2_IMM, 0, 0, 9, 0, 0);
        in_valid = 1;
        #1 chk("flush_busy_kept", in_ready, 1'b0);
        cycle();
        wb_clr = 2'b10; wb_addr = {5'd9, 5'd0};
        cycle();

        // Counter sources.
        clear_inputs();
        stable_counter = 64'h1_0000_0002;
        set_lane(0, 1, CTRL_SRC1_CNTID, CTRL_SRC2_CNTL, 0, 0, 0, 0, 0);
        set_lane(1, 1, CTRL_SRC1_CNTID, CTRL_SRC2_CNTH, 0, 0, 0, 0, 0);
        in_valid = 1;
        cycle();
        chk("cnt_src2", out_src2, {32'h1, 32'h2});
        chk("cnt_src1", out_src1, {CID, CID});

        // Random traffic with an asynchronous reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                #2 rst = 1'b1;
                #1;
                chk("midrst_valid", out_valid, 1'b0);
                chk("midrst_src", {out_src1, out_src2}, 128'd0);
                model_reset();
                clear_inputs();
                @(negedge clk);
                #1 rst = 1'b0;
                @(posedge clk);
                #1;
            end
            rand_inputs();
            cycle();
        end

        clear_inputs();
        repeat (4) cycle();
        chk("drain_q", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
